// File: rtl/cfg_pkg.sv
// Shared tag, error-code and state encodings for the configuration loader.
package cfg_pkg;

  localparam int NUM_FIELDS = 5;

  typedef enum logic [2:0] {
    TAG_NOP    = 3'd0,
    TAG_WIDTH  = 3'd1,
    TAG_HEIGHT = 3'd2,
    TAG_RADDR  = 3'd3,
    TAG_WADDR  = 3'd4,
    TAG_FILTER = 3'd5,
    TAG_RSVD   = 3'd6,
    TAG_END    = 3'd7
  } tag_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_TIMEOUT  = 3'd1,
    ERR_TAG      = 3'd2,
    ERR_DUP      = 3'd3,
    ERR_MISSING  = 3'd4,
    ERR_OVERRUN  = 3'd5,
    ERR_ZERO_DIM = 3'd6
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DECODE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/cfg_fetch_timer.sv
// Wait counter for one read handshake: cleared by load, counts inc cycles.
// expired pulses combinationally on the LIMIT-th consecutive inc cycle.
module cfg_fetch_timer #(
  parameter int LIMIT = 255
) (
  input  logic ahb_hclk,
  input  logic n_rst,
  input  logic load,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = inc && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/cfg_loader.sv
// Fetches a tagged descriptor word by word, validates it into shadow registers and
// commits all fields in one cycle; rd_req is held until rd_ready or the wait timer expires.
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int TAG_W     = 3,
  parameter int DIM_W     = 16,
  parameter int FILTER_W  = 2,
  parameter int MAX_WORDS = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                ahb_hclk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                rd_req,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_ready,
  input  logic [DATA_W-1:0]   rd_data,
  output logic [DIM_W-1:0]    width,
  output logic [DIM_W-1:0]    height,
  output logic [ADDR_W-1:0]   read_start_addr,
  output logic [ADDR_W-1:0]   write_start_addr,
  output logic [FILTER_W-1:0] filter_type,
  output logic                final_enable,
  output logic                busy,
  output logic                error,
  output logic [2:0]          err_code
);

  localparam int PAY_W = DATA_W - TAG_W;
  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  state_e                state, state_next;
  err_e                  err_cause;
  logic [DATA_W-1:0]     hold;
  logic [ADDR_W-1:0]     addr;
  logic [CNT_W-1:0]      word_cnt;
  logic [NUM_FIELDS-1:0] seen, field_bit;
  logic [DIM_W-1:0]      width_sh, height_sh;
  logic [ADDR_W-1:0]     rsa_sh, wsa_sh;
  logic [FILTER_W-1:0]   filter_sh;
  tag_e                  tag;
  logic [PAY_W-1:0]      payload;
  logic                  is_field, dup, handshake, accept, expired, last_word, commit;

  assign tag       = tag_e'(hold[DATA_W-1 -: TAG_W]);
  assign payload   = hold[PAY_W-1:0];
  assign is_field  = (tag >= TAG_WIDTH) && (tag <= TAG_FILTER);
  assign field_bit = is_field ? (NUM_FIELDS'(1) << (3'(tag) - 3'd1)) : '0;
  assign dup       = |(seen & field_bit);
  assign handshake = (state == ST_REQ) && rd_ready;
  assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
  assign last_word = (word_cnt == CNT_W'(MAX_WORDS - 1));
  assign commit    = (state == ST_CHECK) && (state_next == ST_DONE);
  assign rd_addr   = addr;

  // The timer restarts on every handshake and whenever no request is outstanding.
  cfg_fetch_timer #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .ahb_hclk(ahb_hclk),
    .n_rst   (n_rst),
    .load    ((state != ST_REQ) || rd_ready),
    .inc     ((state == ST_REQ) && !rd_ready),
    .expired (expired)
  );

  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    err_cause  = ERR_NONE;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (rd_ready) begin
          state_next = ST_DECODE;
        end else if (expired) begin
          state_next = ST_ERROR;
          err_cause  = ERR_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (tag == TAG_RSVD) begin
          state_next = ST_ERROR;
          err_cause  = ERR_TAG;
        end else if (dup) begin
          state_next = ST_ERROR;
          err_cause  = ERR_DUP;
        end else if (tag == TAG_END) begin
          state_next = ST_CHECK;
        end else if (last_word) begin
          state_next = ST_ERROR;
          err_cause  = ERR_OVERRUN;
        end else begin
          state_next = ST_REQ;
        end
      end
      ST_CHECK: begin
        if (~&seen) begin
          state_next = ST_ERROR;
          err_cause  = ERR_MISSING;
        end else if ((width_sh == '0) || (height_sh == '0)) begin
          state_next = ST_ERROR;
          err_cause  = ERR_ZERO_DIM;
        end else begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_req       = (state == ST_REQ);
    busy         = (state == ST_REQ) || (state == ST_DECODE) || (state == ST_CHECK);
    error        = (state == ST_ERROR);
    final_enable = (state == ST_DONE);
  end

  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) begin
      addr             <= '0;
      hold             <= '0;
      word_cnt         <= '0;
      seen             <= '0;
      err_code         <= '0;
      width_sh         <= '0;
      height_sh        <= '0;
      rsa_sh           <= '0;
      wsa_sh           <= '0;
      filter_sh        <= '0;
      width            <= '0;
      height           <= '0;
      read_start_addr  <= '0;
      write_start_addr <= '0;
      filter_type      <= '0;
    end else begin
      if (accept) begin
        addr     <= base_addr;
        word_cnt <= '0;
        seen     <= '0;
        err_code <= '0;
      end
      if (handshake) hold <= rd_data;
      if (state == ST_DECODE) begin
        word_cnt <= word_cnt + 1'b1;
        addr     <= addr + ADDR_W'(4);
        seen     <= seen | field_bit;
        case (tag)
          TAG_WIDTH:  width_sh  <= DIM_W'(payload);
          TAG_HEIGHT: height_sh <= DIM_W'(payload);
          TAG_RADDR:  rsa_sh    <= ADDR_W'(payload);
          TAG_WADDR:  wsa_sh    <= ADDR_W'(payload);
          TAG_FILTER: filter_sh <= FILTER_W'(payload);
          default: ;
        endcase
      end
      if (err_cause != ERR_NONE) err_code <= err_cause;
      // Committed outputs move only on a fully validated descriptor.
      if (commit) begin
        width            <= width_sh;
        height           <= height_sh;
        read_start_addr  <= rsa_sh;
        write_start_addr <= wsa_sh;
        filter_type      <= filter_sh;
      end
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// Bench for cfg_loader: memory responder with programmable stall plus a descriptor-level model.
module tb_cfg_loader;

  logic        ahb_hclk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data = '0;
  logic [15:0] width, height;
  logic [31:0] read_start_addr, write_start_addr;
  logic [1:0]  filter_type;
  logic        final_enable, busy, error;
  logic [2:0]  err_code;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] desc [$];
  logic [31:0] addr_log [$];
  int          stall_cfg = 0;
  int          waited = 0;

  logic [15:0] cm_width, cm_height;
  logic [31:0] cm_rsa, cm_wsa;
  logic [1:0]  cm_filter;
  bit          exp_ok;
  int          exp_code, exp_n, exp_cyc;
  int          cycles;
  bit          obs_changed, obs_timeout, obs_fe_c1;

  always #5 ahb_hclk = ~ahb_hclk;

  cfg_loader dut (
    .ahb_hclk        (ahb_hclk),
    .n_rst           (n_rst),
    .start           (start),
    .base_addr       (base_addr),
    .rd_req          (rd_req),
    .rd_addr         (rd_addr),
    .rd_ready        (rd_ready),
    .rd_data         (rd_data),
    .width           (width),
    .height          (height),
    .read_start_addr (read_start_addr),
    .write_start_addr(write_start_addr),
    .filter_type     (filter_type),
    .final_enable    (final_enable),
    .busy            (busy),
    .error           (error),
    .err_code        (err_code)
  );

  // Memory slave: answers each request after stall_cfg idle cycles.
  initial begin
    forever begin
      @(posedge ahb_hclk);
      #1;
      if (rd_req) begin
        if (waited < stall_cfg) begin
          rd_ready = 1'b0;
          waited++;
        end else begin
          rd_ready = 1'b1;
          rd_data  = mem.exists(rd_addr) ? mem[rd_addr] : 32'h0;
          addr_log.push_back(rd_addr);
          waited   = 0;
        end
      end else begin
        rd_ready = 1'b0;
        waited   = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Descriptor-level reference: walks words (missing memory reads as NOP) and
  // updates the committed model only on success.
  function automatic void model_run(input int stall);
    bit          seen [1:5];
    logic [28:0] val [1:5];
    logic [31:0] w;
    int          t;
    for (int k = 1; k <= 5; k++) begin
      seen[k] = 1'b0;
      val[k]  = '0;
    end
    exp_ok   = 1'b0;
    exp_code = 0;
    for (int n = 1; n <= 8; n++) begin
      w     = (n <= desc.size()) ? desc[n-1] : 32'h0;
      t     = int'(w[31:29]);
      exp_n = n;
      if (t == 6) begin
        exp_code = 2;
        exp_cyc  = n * (2 + stall) + 1;
        return;
      end
      if (t >= 1 && t <= 5) begin
        if (seen[t]) begin
          exp_code = 3;
          exp_cyc  = n * (2 + stall) + 1;
          return;
        end
        seen[t] = 1'b1;
        val[t]  = w[28:0];
      end
      if (t == 7) begin
        exp_cyc = n * (2 + stall) + 2;
        if (!(seen[1] && seen[2] && seen[3] && seen[4] && seen[5])) exp_code = 4;
        else if (val[1][15:0] == 0 || val[2][15:0] == 0) exp_code = 6;
        else begin
          exp_ok    = 1'b1;
          cm_width  = val[1][15:0];
          cm_height = val[2][15:0];
          cm_rsa    = {3'b000, val[3]};
          cm_wsa    = {3'b000, val[4]};
          cm_filter = val[5][1:0];
        end
        return;
      end
      if (n == 8) begin
        exp_code = 5;
        exp_cyc  = n * (2 + stall) + 1;
        return;
      end
    end
  endfunction

  task automatic run_load(input logic [31:0] base, input int stall, input bit poke, input int limit);
    logic [97:0] snap;
    mem.delete();
    for (int i = 0; i < desc.size(); i++) mem[base + 32'(4 * i)] = desc[i];
    stall_cfg   = stall;
    addr_log.delete();
    obs_changed = 1'b0;
    obs_timeout = 1'b0;
    snap = {width, height, read_start_addr, write_start_addr, filter_type};
    @(posedge ahb_hclk);
    #1;
    start     = 1'b1;
    base_addr = base;
    @(posedge ahb_hclk);
    #1;
    start     = 1'b0;
    base_addr = $urandom();
    cycles    = 1;
    obs_fe_c1 = final_enable;
    while (!(final_enable || error)) begin
      if ({width, height, read_start_addr, write_start_addr, filter_type} !== snap) obs_changed = 1'b1;
      if (cycles >= limit) begin
        obs_timeout = 1'b1;
        break;
      end
      if (poke) begin
        start     = 1'($urandom_range(0, 1));
        base_addr = $urandom();
      end
      @(posedge ahb_hclk);
      #1;
      cycles++;
    end
    start = 1'b0;
    total++;
    if (obs_timeout) begin
      bad++;
      $display("FAIL load_bound no final_enable/error after %0d cycles", cycles);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    cm_width = '0; cm_height = '0; cm_rsa = '0; cm_wsa = '0; cm_filter = '0;
    repeat (3) @(posedge ahb_hclk);
    #1;
    total++;
    if ({width, height, read_start_addr, write_start_addr, filter_type} !== 98'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {width, height, read_start_addr, write_start_addr, filter_type});
    end
    total++;
    if ({final_enable, busy, error, rd_req} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {final_enable, busy, error, rd_req});
    end
    total++;
    if (err_code !== 3'd0) begin bad++; $display("FAIL reset_err_code got=%0d want=0", err_code); end
    n_rst = 1'b1;
    repeat (2) @(posedge ahb_hclk);
    #1;
    total++;
    if ({busy, rd_req, final_enable} !== 3'b000) begin
      bad++; $display("FAIL idle_hold got=%b want=000", {busy, rd_req, final_enable});
    end
  endtask

  task automatic load_nominal(input logic [31:0] base, input int stall, input string name);
    desc = '{32'h20000151, 32'h40000151, 32'h600001F4, 32'h8000157C, 32'hA0000001, 32'hE0000000};
    model_run(stall);
    run_load(base, stall, 1'b0, 400);
    total++;
    if (cycles !== exp_cyc) begin bad++; $display("FAIL %s_cycle got=%0d want=%0d", name, cycles, exp_cyc); end
    total++;
    if ({final_enable, error, err_code} !== 5'b10000) begin
      bad++; $display("FAIL %s_status got fe=%b err=%b code=%0d want fe=1 err=0 code=0", name, final_enable, error, err_code);
    end
    total++;
    if ({width, height, read_start_addr, write_start_addr, filter_type} !==
        {16'h151, 16'h151, 32'h1F4, 32'h157C, 2'd1}) begin
      bad++; $display("FAIL %s_values got w=%h h=%h r=%h wr=%h f=%0d", name, width, height, read_start_addr, write_start_addr, filter_type);
    end
    total++;
    if (addr_log.size() !== 6) begin
      bad++; $display("FAIL %s_nreads got=%0d want=6", name, addr_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (addr_log[i] !== base + 32'(4 * i)) begin
          bad++; $display("FAIL %s_rd_addr%0d got=%h want=%h", name, i, addr_log[i], base + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_nominal();
    load_nominal(32'h0000_0D08, 0, "nominal");
    total++;
    if (cycles !== 14) begin bad++; $display("FAIL nominal_done_cycle got=%0d want=14", cycles); end
  endtask

  task automatic test_stall();
    load_nominal(32'h0000_0D08, 3, "stall3");
    total++;
    if (cycles !== 32) begin bad++; $display("FAIL stall_done_cycle got=%0d want=32", cycles); end
  endtask

  task automatic test_reload();
    desc = '{32'h20000280, 32'h40000151, 32'h600001F4, 32'h8000157C, 32'hA0000001, 32'hE0000000};
    model_run(0);
    run_load(32'h0000_3000, 0, 1'b1, 200);
    total++;
    if (obs_fe_c1 !== 1'b0) begin bad++; $display("FAIL reload_fe_drop got=%b want=0", obs_fe_c1); end
    total++;
    if (obs_changed !== 1'b0) begin bad++; $display("FAIL reload_held outputs changed mid-load"); end
    total++;
    if (final_enable !== 1'b1 || width !== 16'h280) begin
      bad++; $display("FAIL reload_commit got fe=%b w=%h want fe=1 w=0280", final_enable, width);
    end
    total++;
    if (cycles !== 14 || addr_log.size() !== 6) begin
      bad++; $display("FAIL reload_ignore_start got cyc=%0d reads=%0d want 14/6", cycles, addr_log.size());
    end
  endtask

  task automatic test_errors();
    int want;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: desc = '{32'h20000151, 32'hC0000000, 32'h40000151, 32'hE0000000};
        1: desc = '{32'h20000151, 32'h20000200, 32'h40000151, 32'hE0000000};
        2: desc = '{32'h20000151, 32'h600001F4, 32'h8000157C, 32'hA0000001, 32'hE0000000};
        default: desc = '{32'h20000000, 32'h40000151, 32'h600001F4, 32'h8000157C, 32'hA0000001, 32'hE0000000};
      endcase
      want = (k == 0) ? 2 : (k == 1) ? 3 : (k == 2) ? 4 : 6;
      model_run(0);
      run_load(32'h0000_2000, 0, 1'b0, 200);
      total++;
      if (error !== 1'b1 || err_code !== 3'(want)) begin
        bad++; $display("FAIL err_case%0d got err=%b code=%0d want err=1 code=%0d", k, error, err_code, want);
      end
      total++;
      if ({width, height, read_start_addr, write_start_addr, filter_type} !== {cm_width, cm_height, cm_rsa, cm_wsa, cm_filter}
          || obs_changed !== 1'b0) begin
        bad++; $display("FAIL err_case%0d_outputs got w=%h h=%h want w=%h h=%h", k, width, height, cm_width, cm_height);
      end
      total++;
      if (cycles !== exp_cyc) begin bad++; $display("FAIL err_case%0d_cycle got=%0d want=%0d", k, cycles, exp_cyc); end
    end
  endtask

  task automatic test_timeout();
    desc = '{32'h20000151, 32'h40000151, 32'h600001F4, 32'h8000157C, 32'hA0000001, 32'hE0000000};
    run_load(32'h0000_0D08, 1000, 1'b0, 400);
    total++;
    if (error !== 1'b1 || err_code !== 3'd1) begin
      bad++; $display("FAIL timeout_code got err=%b code=%0d want err=1 code=1", error, err_code);
    end
    total++;
    if (cycles !== 256) begin bad++; $display("FAIL timeout_cycle got=%0d want=256", cycles); end
    total++;
    if (width !== cm_width || addr_log.size() !== 0) begin
      bad++; $display("FAIL timeout_side got w=%h reads=%0d want w=%h reads=0", width, addr_log.size(), cm_width);
    end
  endtask

  task automatic test_nop_overrun();
    desc.delete();
    model_run(0);
    run_load(32'h0000_0040, 0, 1'b0, 200);
    total++;
    if (err_code !== 3'd5 || error !== 1'b1) begin
      bad++; $display("FAIL overrun_code got err=%b code=%0d want err=1 code=5", error, err_code);
    end
    total++;
    if (cycles !== exp_cyc) begin bad++; $display("FAIL overrun_cycle got=%0d want=%0d", cycles, exp_cyc); end
    repeat (6) @(posedge ahb_hclk);
    #1;
    total++;
    if (addr_log.size() !== 8 || rd_req !== 1'b0) begin
      bad++; $display("FAIL overrun_reads got=%0d rd_req=%b want 8 and 0", addr_log.size(), rd_req);
    end
  endtask

  task automatic test_reset_midload();
    int guard;
    desc = '{32'h20000151, 32'h40000151, 32'h600001F4, 32'h8000157C, 32'hA0000001, 32'hE0000000};
    mem.delete();
    for (int i = 0; i < desc.size(); i++) mem[32'h100 + 32'(4 * i)] = desc[i];
    stall_cfg = 0;
    addr_log.delete();
    @(posedge ahb_hclk);
    #1;
    start = 1'b1; base_addr = 32'h100;
    @(posedge ahb_hclk);
    #1;
    start = 1'b0;
    guard = 0;
    while (addr_log.size() < 3 && guard < 50) begin
      @(posedge ahb_hclk);
      #1;
      guard++;
    end
    total++;
    if (addr_log.size() < 3) begin bad++; $display("FAIL midload_reach got=%0d reads want>=3", addr_log.size()); end
    @(posedge ahb_hclk);
    #3;
    n_rst = 1'b0;
    #1;
    total++;
    if ({width, height, read_start_addr, write_start_addr, filter_type} !== 98'h0 || err_code !== 3'd0) begin
      bad++; $display("FAIL midload_reset_outputs got w=%h h=%h code=%0d want 0", width, height, err_code);
    end
    total++;
    if ({final_enable, busy, error, rd_req} !== 4'b0000) begin
      bad++; $display("FAIL midload_reset_flags got=%b want=0000", {final_enable, busy, error, rd_req});
    end
    cm_width = '0; cm_height = '0; cm_rsa = '0; cm_wsa = '0; cm_filter = '0;
    @(negedge ahb_hclk);
    n_rst = 1'b1;
    load_nominal(32'h0000_0100, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] base;
    logic [28:0] pl;
    int          kind, stall, tmp, j;
    bit          poke;
    int          tags [$];
    for (int it = 0; it < 20; it++) begin
      tags = '{1, 2, 3, 4, 5};
      for (int i = 4; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = tags[i]; tags[i] = tags[j]; tags[j] = tmp;
      end
      kind = $urandom_range(0, 6);
      if (kind == 3) tags.delete($urandom_range(0, 4));
      if (kind == 2) tags.insert($urandom_range(0, 5), tags[$urandom_range(0, 4)]);
      desc.delete();
      foreach (tags[i]) begin
        pl = 29'($urandom());
        if (kind == 5 && tags[i] == 1) pl[15:0] = 16'h0;
        desc.push_back({3'(tags[i]), pl});
      end
      if (kind == 1) desc.insert($urandom_range(0, desc.size()), 32'h0);
      if (kind == 4) desc.insert($urandom_range(0, desc.size()), {3'd6, 29'($urandom())});
      if (kind != 6) desc.push_back({3'd7, 29'($urandom())});
      stall = $urandom_range(0, 2);
      poke  = 1'($urandom_range(0, 1));
      base  = (it == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
      model_run(stall);
      run_load(base, stall, poke, 400);
      total++;
      if (final_enable !== exp_ok || err_code !== 3'(exp_code)) begin
        bad++; $display("FAIL rand%0d_status got fe=%b code=%0d want fe=%b code=%0d", it, final_enable, err_code, exp_ok, exp_code);
      end
      total++;
      if (cycles !== exp_cyc) begin bad++; $display("FAIL rand%0d_cycle got=%0d want=%0d", it, cycles, exp_cyc); end
      total++;
      if ({width, height, read_start_addr, write_start_addr, filter_type} !== {cm_width, cm_height, cm_rsa, cm_wsa, cm_filter}) begin
        bad++; $display("FAIL rand%0d_outputs got=%h want=%h", it, {width, height, read_start_addr, write_start_addr, filter_type},
                        {cm_width, cm_height, cm_rsa, cm_wsa, cm_filter});
      end
      total++;
      if (obs_changed !== 1'b0) begin bad++; $display("FAIL rand%0d_held outputs changed mid-load", it); end
      total++;
      if (addr_log.size() !== exp_n) begin
        bad++; $display("FAIL rand%0d_nreads got=%0d want=%0d", it, addr_log.size(), exp_n);
      end else begin
        for (int i = 0; i < exp_n; i++) begin
          total++;
          if (addr_log[i] !== base + 32'(4 * i)) begin
            bad++; $display("FAIL rand%0d_rd_addr%0d got=%h want=%h", it, i, addr_log[i], base + 32'(4 * i));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_reload();
    test_errors();
    test_timeout();
    test_nop_overrun();
    test_reset_midload();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
